// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared note codes, entry layout and player state for the piano recorder
package piano_pkg;

  localparam logic [2:0] NOTE_REST = 3'd0;
  localparam logic [2:0] NOTE_C    = 3'd1;
  localparam logic [2:0] NOTE_D    = 3'd2;
  localparam logic [2:0] NOTE_E    = 3'd3;
  localparam logic [2:0] NOTE_F    = 3'd4;
  localparam logic [2:0] NOTE_G    = 3'd5;
  localparam logic [2:0] NOTE_A    = 3'd6;
  localparam logic [2:0] NOTE_B    = 3'd7;

  localparam logic [2:0] OCT_MIN     = 3'd1;
  localparam logic [2:0] OCT_MAX     = 3'd7;
  localparam logic [2:0] OCT_DEFAULT = 3'd4;

  // Recording entry: {octave[2:0], note[2:0]}
  localparam int ENTRY_W      = 6;
  localparam int ENT_OCT_LSB  = 3;
  localparam int ENT_NOTE_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4
  } player_state_t;

  function automatic logic [2:0] entry_octave(input logic [ENTRY_W-1:0] ent);
    return ent[ENT_OCT_LSB +: 3];
  endfunction

  function automatic logic [2:0] entry_note(input logic [ENTRY_W-1:0] ent);
    return ent[ENT_NOTE_LSB +: 3];
  endfunction

endpackage

// File: rtl/note_timer.sv
// rtl/note_timer.sv - loadable down-counter with zero flag, shared by PLAY and GAP
module note_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load on state entry, then count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/recording_player.sv
// rtl/recording_player.sv - plays recorded {octave, note} entries to the amplifier
module recording_player
  import piano_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int TICKS_PER_NOTE = 250000,
  parameter int GAP_TICKS      = 2500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] rec_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [5:0]        rd_data,
  output logic [2:0]        octave,
  output logic [2:0]        note,
  output logic              busy,
  output logic              done
);

  localparam int MAX_TICKS = (TICKS_PER_NOTE > GAP_TICKS) ? TICKS_PER_NOTE : GAP_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam bit HAS_GAP   = (GAP_TICKS != 0);
  localparam logic [CNT_W-1:0] PLAY_LD = CNT_W'(TICKS_PER_NOTE - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(HAS_GAP ? GAP_TICKS - 1 : 0);

  player_state_t     state;
  logic [ADDR_W-1:0] len_q;
  logic              last_entry;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_zero;

  // rd_addr doubles as the read pointer; it never moves past len_q-1
  assign last_entry = (rd_addr == len_q - ADDR_W'(1));

  // The timer is reloaded on entry to PLAY (from WAIT) and to GAP (from PLAY)
  assign tmr_load = (state == ST_WAIT) || ((state == ST_PLAY) && tmr_zero);
  assign tmr_val  = (state == ST_WAIT) ? PLAY_LD : GAP_LD;

  note_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Playback FSM with registered read strobe, note outputs and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      len_q   <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      octave  <= '0;
      note    <= NOTE_REST;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      if (stop) begin
        state  <= ST_IDLE;
        octave <= '0;
        note   <= NOTE_REST;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (rec_len != '0) begin
                state   <= ST_FETCH;
                len_q   <= rec_len;
                rd_addr <= '0;
                rd_en   <= 1'b1;
                busy    <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          ST_FETCH: begin
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            state  <= ST_PLAY;
            octave <= entry_octave(rd_data);
            note   <= entry_note(rd_data);
          end
          ST_PLAY: begin
            if (tmr_zero) begin
              octave <= '0;
              note   <= NOTE_REST;
              if (HAS_GAP) begin
                state <= ST_GAP;
              end else if (last_entry) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state   <= ST_FETCH;
                rd_addr <= rd_addr + ADDR_W'(1);
                rd_en   <= 1'b1;
              end
            end
          end
          ST_GAP: begin
            if (tmr_zero) begin
              if (last_entry) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state   <= ST_FETCH;
                rd_addr <= rd_addr + ADDR_W'(1);
                rd_en   <= 1'b1;
              end
            end
          end
          default: begin
            state  <= ST_IDLE;
            octave <= '0;
            note   <= NOTE_REST;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/recording_player.md
# recording_player

Playback engine for the piano's note recording. It reads 6-bit `{octave, note}` entries out of the recording buffer's synchronous read port and drives one note at a time, with a fixed duration per note and a silent gap between notes, to the amplifier's `octave`/`note` inputs. It sits between the recording buffer and the amplifier and runs on the 1 MHz domain. It is the reader counterpart of the recording writer, which owns `idx_wr`.

## Interface
Parameters:
- `ADDR_W`, 8: buffer address width; 2^ADDR_W entries.
- `TICKS_PER_NOTE`, 250000: clocks each entry is held; must be ≥ 1.
- `GAP_TICKS`, 2500: silent clocks after each entry; 0 is legal.

Ports:
- `clk`  in  1  playback clock (`clk_1M` at top level).
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins playback from address 0.
- `stop`  in  1  single-cycle pulse; aborts playback.
- `rec_len`  in  ADDR_W  number of valid entries (writer's `idx_wr`); sampled on an accepted `start`.
- `rd_en`  out  1  buffer read strobe.
- `rd_addr`  out  ADDR_W  buffer read address.
- `rd_data`  in  6  buffer entry; valid one clock after `rd_en`.
- `octave`  out  3  octave to the amplifier.
- `note`  out  3  note to the amplifier; 0 = silence.
- `busy`  out  1  high while not IDLE.
- `done`  out  1  one-cycle pulse on natural end of the recording.

## Operation
- States:
  - IDLE → FETCH on `start` when `rec_len` ≠ 0.
  - IDLE stays IDLE on `start` when `rec_len` = 0, and pulses `done` on the next clock.
  - FETCH (drive `rd_en`/`rd_addr`) → WAIT.
  - WAIT (capture `rd_data`) → PLAY.
  - PLAY → GAP after TICKS_PER_NOTE clocks; PLAY → FETCH directly when GAP_TICKS = 0 and more entries remain.
  - GAP → FETCH after GAP_TICKS clocks.
  - Last entry: the exit of its GAP (or of its PLAY when GAP_TICKS = 0) goes to IDLE with `done` = 1 for one clock.
- Entry layout: octave in `rd_data[5:3]`, note in `rd_data[2:0]`. An entry with note 0 is a rest: it plays for its full duration with silent output.
- Entry values pass through unchanged; range checking is the writer's job.
- `rec_len` and the read pointer are latched at `start`. Later changes to `rec_len` have no effect on a playback in progress.
- The read pointer is ADDR_W bits wide and counts 0 to `rec_len`−1. With `rec_len` = 2^ADDR_W−1 it never wraps.
- `start` while busy is ignored.
- `stop` in any state goes to IDLE on the next clock with `note` = 0 and `octave` = 0; `done` is not pulsed.
- `start` and `stop` in the same cycle: `stop` wins.
- `octave`/`note` are registered. They are 0 in IDLE, FETCH, WAIT and GAP, and hold the captured entry during PLAY.
- Reset values: `octave` = `note` = 0, `rd_en` = 0, `rd_addr` = 0, `busy` = 0, `done` = 0, state = IDLE. Assertion of `rst_n` clears all of them immediately, including mid-note.

## Timing
- `start` sampled at edge 0:
  - FETCH at edge 1 (`rd_en` = 1, `rd_addr` = 0).
  - Data captured at edge 2.
  - `note` valid after edge 3.
- Per-entry period = TICKS_PER_NOTE + GAP_TICKS + 2 clocks. The 2 extra clocks are FETCH and WAIT, both silent.
- `rd_en` is high for exactly one clock per entry.
- Duration counter width = $clog2(max(TICKS_PER_NOTE, GAP_TICKS) + 1). It loads N−1 on state entry and advances state when it reaches 0.
- `busy` rises the clock after an accepted `start` and falls on the same edge that `done` rises.

## Structure
- Shared package `piano_pkg` holds:
  - note codes: NOTE_REST = 0, NOTE_C = 1 … NOTE_B = 7;
  - OCT_MIN = 1, OCT_MAX = 7, OCT_DEFAULT = 4;
  - entry field positions;
  - the player state enum.
  
  The writer uses the same package.
- One sub-module, `note_timer`: a loadable down-counter with a zero flag, instantiated once and shared by PLAY and GAP.

## Test plan
All scenarios use ADDR_W = 4, TICKS_PER_NOTE = 4, GAP_TICKS = 1.
- Buffer [0x21, 0x23, 0x27] (octave 4: C, E, B), `rec_len` = 3, pulse `start` → `note` sequence 1, 3, 7, each held 4 clocks with 3 silent clocks between; `done` once at clock 3 + 3×7 − 1; `busy` low afterwards.
- `rec_len` = 0, `start` → no `rd_en`; `done` pulse one clock later; `busy` stays 0.
- Entry 0x20 (rest) between two notes → `note` = 0 for 4 clocks in that slot; total run time unchanged.
- `stop` during the 2nd note's PLAY → IDLE next clock, `note` = 0, no `done`; a following `start` replays from address 0.
- Deassert `rst_n` mid-PLAY → `note`, `octave`, `busy` = 0 immediately (asynchronously); no `rd_en` until a new `start`.
- `start` while busy, and `start` + `stop` in the same IDLE cycle → both ignored; playback sequence unchanged / stays IDLE.
